data_stack: RTL

- Hardware operand stack that sits directly upstream of the processor's observable `top_of_stack` / `second_of_stack` outputs.
- The control unit issues one stack operation per cycle, and the ALU result or `getin` value arrives on `din`.
- The block holds top and second in dedicated registers and spills deeper entries to an internal array.
- It flags overflow and underflow.

---
 rtl/data_stack.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_stack.sv
// Operand stack with top/second held in registers and deeper entries spilled to an array.
// Illegal operations leave the stack untouched and raise sticky overflow/underflow flags.
module data_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top_of_stack,
   output logic [WIDTH-1:0] second_of_stack,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   // Array holds entries 3..DEPTH; pointer counts how many of them are in use.
   localparam int ARR = (DEPTH > 2) ? DEPTH - 2 : 1;
   localparam int PW  = (ARR > 1) ? $clog2(ARR + 1) : 1;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_PUSH  = 3'b001;
   localparam logic [2:0] OP_POP   = 3'b010;
   localparam logic [2:0] OP_REPL  = 3'b011;
   localparam logic [2:0] OP_BINOP = 3'b100;
   localparam logic [2:0] OP_SWAP  = 3'b101;
   localparam logic [2:0] OP_DUP   = 3'b110;

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_TWO   = CW'(2);
   localparam logic [CW-1:0] CNT_THREE = CW'(3);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   logic [WIDTH-1:0] mem [0:ARR-1];
   logic [PW-1:0]    ptr_r;
   logic [WIDTH-1:0] top_r, second_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r, underflow_r;

   logic [WIDTH-1:0] top_n, second_n, head;
   logic [CW-1:0]    count_n;
   logic             spill, refill, ovf_set, unf_set;
   logic             is_empty, is_full, has_two, has_three;
   logic [PW-1:0]    ptr_m1;

   assign is_empty  = (count_r == '0);
   assign is_full   = (count_r == CNT_FULL);
   assign has_two   = (count_r >= CNT_TWO);
   assign has_three = (count_r >= CNT_THREE);
   assign ptr_m1    = ptr_r - PW'(1);
   // Only consumed on a refill, which requires at least one array entry.
   assign head      = mem[ptr_m1];

   always_comb begin
      top_n    = top_r;
      second_n = second_r;
      count_n  = count_r;
      spill    = 1'b0;
      refill   = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      case (op)
         OP_PUSH: begin
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               top_n    = din;
               second_n = top_r;
               spill    = has_two;
               count_n  = count_r + CNT_ONE;
            end
         end
         OP_POP: begin
            if (is_empty) begin
               unf_set = 1'b1;
            end else begin
               top_n    = second_r;
               second_n = has_three ? head : '0;
               refill   = has_three;
               count_n  = count_r - CNT_ONE;
            end
         end
         OP_REPL: begin
            if (is_empty) unf_set = 1'b1;
            else          top_n   = din;
         end
         OP_BINOP: begin
            if (!has_two) begin
               unf_set = 1'b1;
            end else begin
               top_n    = din;
               second_n = has_three ? head : '0;
               refill   = has_three;
               count_n  = count_r - CNT_ONE;
            end
         end
         OP_SWAP: begin
            if (!has_two) begin
               unf_set = 1'b1;
            end else begin
               top_n    = second_r;
               second_n = top_r;
            end
         end
         OP_DUP: begin
            // Empty check wins over full check.
            if (is_empty) begin
               unf_set = 1'b1;
            end else if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               second_n = top_r;
               spill    = has_two;
               count_n  = count_r + CNT_ONE;
            end
         end
         OP_NOP:  ;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         top_r       <= '0;
         second_r    <= '0;
         count_r     <= '0;
         ptr_r       <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         top_r       <= top_n;
         second_r    <= second_n;
         count_r     <= count_n;
         overflow_r  <= overflow_r | ovf_set;
         underflow_r <= underflow_r | unf_set;
         if (spill)       ptr_r <= ptr_r + PW'(1);
         else if (refill) ptr_r <= ptr_m1;
      end
   end

   // Array contents are don't-care after reset, so no reset branch here.
   always_ff @(posedge CLK) begin
      if (reset && spill) mem[ptr_r] <= second_r;
   end

   assign top_of_stack    = (count_r >= CNT_ONE) ? top_r : '0;
   assign second_of_stack = has_two ? second_r : '0;
   assign count           = count_r;
   assign empty           = is_empty;
   assign full            = is_full;
   assign overflow        = overflow_r;
   assign underflow       = underflow_r;

endmodule
